// File: rtl/tinyalu_arbiter_if.sv
// Requester and TinyALU signals of the arbiter, bundled for the port list.
// slave is the arbiter's view; master is the view of the surrounding agents and ALU.
interface tinyalu_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_A;
    logic [8*NUM_REQ-1:0] req_B;
    logic [3*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [15:0]          rsp_result;
    logic                 rsp_error;
    logic [7:0]           alu_A;
    logic [7:0]           alu_B;
    logic [2:0]           alu_op;
    logic                 alu_start;
    logic                 alu_done;
    logic [15:0]          alu_result;

    modport slave (
        input  req_valid, req_A, req_B, req_op, alu_done, alu_result,
        output req_ready, rsp_valid, rsp_result, rsp_error,
               alu_A, alu_B, alu_op, alu_start
    );

    modport master (
        output req_valid, req_A, req_B, req_op, alu_done, alu_result,
        input  req_ready, rsp_valid, rsp_result, rsp_error,
               alu_A, alu_B, alu_op, alu_start
    );
endinterface

// File: rtl/tinyalu_arbiter.sv
// Round-robin sharing of one TinyALU among NUM_REQ requesters; response one cycle after alu_done
// (no-op/illegal: one cycle after grant); one request in flight, others hold req_valid until req_ready.
module tinyalu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 31
) (
    input logic             clk,
    input logic             reset_n,
    tinyalu_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [WD_W-1:0]   wdog;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_vld;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [7:0]        a_arr  [NUM_REQ];
    logic [7:0]        b_arr  [NUM_REQ];
    logic [2:0]        op_arr [NUM_REQ];
    logic [7:0]        sel_a;
    logic [7:0]        sel_b;
    logic [2:0]        sel_op;
    logic              sel_alu;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i]  = bus.req_A[8*i +: 8];
            b_arr[i]  = bus.req_B[8*i +: 8];
            op_arr[i] = bus.req_op[3*i +: 3];
        end
    end

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_vld && bus.req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
        req_ready_c = '0;
        if (state == IDLE && gnt_vld) req_ready_c[gnt_idx] = 1'b1;
    end

    assign bus.req_ready = req_ready_c;
    assign sel_a   = a_arr[gnt_idx];
    assign sel_b   = b_arr[gnt_idx];
    assign sel_op  = op_arr[gnt_idx];
    assign sel_alu = (sel_op != 3'd0) && (sel_op <= 3'd4);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            id_q           <= '0;
            wdog           <= '0;
            bus.rsp_valid  <= '0;
            bus.rsp_result <= '0;
            bus.rsp_error  <= 1'b0;
            bus.alu_start  <= 1'b0;
            bus.alu_A      <= '0;
            bus.alu_B      <= '0;
            bus.alu_op     <= '0;
        end else begin
            bus.rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        id_q   <= gnt_idx;
                        rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        wdog   <= '0;
                        if (sel_alu) begin
                            bus.alu_A     <= sel_a;
                            bus.alu_B     <= sel_b;
                            bus.alu_op    <= sel_op;
                            bus.alu_start <= 1'b1;
                            state         <= ISSUE;
                        end else begin
                            // no-op and illegal opcodes are answered without touching the ALU
                            bus.rsp_valid  <= req_ready_c;
                            bus.rsp_result <= 16'h0000;
                            bus.rsp_error  <= (sel_op != 3'd0);
                            state          <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.alu_done) begin
                        bus.alu_start  <= 1'b0;
                        bus.rsp_valid  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;
                        bus.rsp_result <= bus.alu_result;
                        bus.rsp_error  <= 1'b0;
                        state          <= RESP;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        bus.alu_start  <= 1'b0;
                        bus.rsp_valid  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;
                        bus.rsp_result <= 16'h0000;
                        bus.rsp_error  <= 1'b1;
                        state          <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
